config_reg_bank_loader: RTL and testbench
=========================================

// Module: config_reg_bank_loader
//
// PURPOSE
// Parametrised successor of the single-register UART config loader. Holds NUM_REGS
// config registers, each REG_BYTES bytes wide, written from the UART RX byte stream.
// Byte 0 of a transfer selects the register; the next REG_BYTES bytes are the value, MSB first.
// Adds atomic commit, per-register update strobes, bad-index and inter-byte timeout
// errors, and clean abort. Sits between the command decoder (activate/done) and the
// sampler/trigger blocks (clock divider, trigger level, pre-trigger depth...).
//
// PARAMETERS
// NUM_REGS       4        number of config registers (1..256)
// REG_BYTES      2        bytes per register (1..4); REG_W = 8*REG_BYTES
// RESET_VAL      0        reset/default value of every register (REG_W bits)
// TIMEOUT_CYCLES 1000000  max clk cycles between accepted bytes; 0 disables timeout
//
// PORTS
// clk        in   1                 system clock
// rst        in   1                 asynchronous reset, active-low
// activate   in   1                 decoder request; held high for the whole transfer
// done       out  1                 transfer finished (ok or error); held until activate low
// error      out  1                 valid while done=1: bad index or timeout
// rx_data    in   8                 UART received byte
// rx_ready   in   1                 one-cycle strobe, rx_data valid
// cfg_regs   out  NUM_REGS*REG_W    flattened registers; reg i = cfg_regs[i*REG_W +: REG_W]
// cfg_update out  NUM_REGS          one-cycle pulse on bit i when reg i changes
//
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, all regs = RESET_VAL, done=0, error=0,
//   cfg_update=0, shadow/index/byte counter/timeout counter cleared.
// - States: IDLE -> RECV_IDX -> RECV_DATA -> FINISH -> IDLE.
//   IDLE: done=0, error=0; activate=1 -> RECV_IDX (next edge).
//   RECV_IDX: rx_ready -> latch index = rx_data, clear byte count -> RECV_DATA.
//   RECV_DATA: each rx_ready shifts rx_data into shadow LSB side (shadow<<8|byte),
//     count++; on REG_BYTES-th byte -> FINISH, same edge commits.
//   FINISH: done=1; activate=0 -> IDLE.
// - Commit: at the edge accepting the last data byte, if index<NUM_REGS, reg[index]
//   <= {shadow, rx_data} and cfg_update[index]=1 for exactly that cycle; done rises
//   same edge. Other registers never change. Latency: last rx_ready edge -> new value.
// - Bad index (index>=NUM_REGS): data bytes still consumed; no reg written, no
//   cfg_update; FINISH with error=1.
// - Timeout (TIMEOUT_CYCLES>0): counter cleared on entry to RECV_IDX and on every
//   accepted byte; increments each cycle in RECV_IDX/RECV_DATA without rx_ready;
//   reaching TIMEOUT_CYCLES -> FINISH with error=1, no commit.
// - activate falling in RECV_IDX/RECV_DATA: abort -> IDLE, no commit, done never pulses.
// - rx_ready while IDLE or FINISH: ignored. rx_ready and timeout same cycle: byte wins.
// - REG_BYTES=1: single data byte commits. Value write equal to old value still
//   pulses cfg_update.
//
// STRUCTURE
// - Package config_pkg: state enum cfg_state_t {IDLE,RECV_IDX,RECV_DATA,FINISH};
//   register index constants (CFG_CLK_DIV=0, CFG_TRIG_LVL=1, ...).
// - Sub-module cfg_timeout_counter (clk, rst, clear, enable -> expired), parametrised
//   by TIMEOUT_CYCLES, width $clog2(TIMEOUT_CYCLES+1); constant expired=0 when 0.
// - Register bank: generate loop over NUM_REGS with per-register write enable.
//
// TESTING
// - Reset: after rst release all regs=RESET_VAL, done=0, error=0, cfg_update=0.
// - Write 0x01,0x12,0x34 (defaults) -> reg1=0x1234, cfg_update=4'b0010 one cycle, done=1,
//   error=0; reg0/2/3 unchanged; done drops 1 cycle after activate low.
// - Bad index 0x07,0xAA,0xBB -> no reg change, cfg_update=0, done=1, error=1.
// - TIMEOUT_CYCLES=50: send 0x00,0x55 then silence -> done=1,error=1 at 50 cycles
//   after 0x55; reg0 unchanged.
// - Abort: send 0x02,0x99, drop activate -> IDLE, reg2 unchanged, done stays 0;
//   next full transfer 0x02,0xDE,0xAD -> reg2=0xDEAD.
// - Async reset mid-RECV_DATA -> immediate IDLE, regs=RESET_VAL; REG_BYTES=4 run
//   0x00,0x01,0x02,0x03,0x04 -> reg0=0x01020304.

Source files
------------

// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Package : config_pkg
// Brief   : Shared state encoding and register map for the config bank loader.
// Rev     : 1.0
// ============================================================================
package config_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECV_IDX  = 2'd1,
        RECV_DATA = 2'd2,
        FINISH    = 2'd3
    } cfg_state_t;

    // Register map as seen by the sampler/trigger blocks.
    localparam int CFG_CLK_DIV       = 0;
    localparam int CFG_TRIG_LVL      = 1;
    localparam int CFG_PRETRIG_DEPTH = 2;
    localparam int CFG_TRIG_MASK     = 3;

endpackage
`default_nettype wire

// File: rtl/cfg_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module : cfg_timeout_counter
// Brief  : Inter-byte idle counter; expired_o flags the cycle the limit is hit.
// Rev    : 1.0
// ============================================================================
module cfg_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clear_i, enable_i};
            assign expired_o     = 1'b0;
        end else begin : g_enabled
            localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES - 1);
            localparam logic [c_cnt_w-1:0] c_one   = 1;

            logic [c_cnt_w-1:0] count_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_q <= '0;
                end else if (clear_i) begin
                    count_q <= '0;
                end else if (enable_i) begin
                    count_q <= count_q + c_one;
                end
            end

            // Fires while the counter is about to reach the limit, so the
            // caller's state changes on the very edge the limit is reached.
            assign expired_o = enable_i && (count_q == c_limit);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/config_reg_bank_loader.sv
`default_nettype none
// ============================================================================
// Module : config_reg_bank_loader
// Brief  : Loads NUM_REGS config registers from a UART byte stream (index, MSB-first value).
// Rev    : 1.0
// ============================================================================
module config_reg_bank_loader
    import config_pkg::*;
#(
    parameter int                     NUM_REGS       = 4,
    parameter int                     REG_BYTES      = 2,
    parameter logic [8*REG_BYTES-1:0] RESET_VAL      = '0,
    parameter int                     TIMEOUT_CYCLES = 1000000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              activate_i,
    output logic                              done_o,
    output logic                              error_o,
    input  logic [7:0]                        rx_data_i,
    input  logic                              rx_ready_i,
    output logic [NUM_REGS*8*REG_BYTES-1:0]   cfg_regs_o,
    output logic [NUM_REGS-1:0]               cfg_update_o
);

    localparam int               c_reg_w     = 8 * REG_BYTES;
    localparam logic [2:0]       c_last_byte = 3'(REG_BYTES - 1);
    localparam logic [8:0]       c_num_regs  = 9'(NUM_REGS);

    cfg_state_t           state_q, state_d;
    logic [7:0]           idx_q, idx_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [c_reg_w-1:0]   shadow_q, shadow_d;
    logic                 err_q, err_d;

    logic                 w_in_recv;
    logic                 w_expired;
    logic                 w_bad_idx;
    logic                 w_commit;
    logic [c_reg_w-1:0]   w_value;

    assign w_in_recv = (state_q == RECV_IDX) || (state_q == RECV_DATA);
    assign w_bad_idx = ({1'b0, idx_q} >= c_num_regs);
    assign w_value   = (shadow_q << 8) | c_reg_w'(rx_data_i);

    cfg_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!w_in_recv || rx_ready_i),
        .enable_i  (w_in_recv && !rx_ready_i),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
        end
    end

    // Abort (activate low) beats everything; an arriving byte beats timeout.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        w_commit = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (activate_i) begin
                    state_d = RECV_IDX;
                end
            end
            RECV_IDX: begin
                if (!activate_i) begin
                    state_d = IDLE;
                end else if (rx_ready_i) begin
                    idx_d    = rx_data_i;
                    cnt_d    = '0;
                    shadow_d = '0;
                    state_d  = RECV_DATA;
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            RECV_DATA: begin
                if (!activate_i) begin
                    state_d = IDLE;
                end else if (rx_ready_i) begin
                    shadow_d = w_value;
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q == c_last_byte) begin
                        state_d  = FINISH;
                        err_d    = w_bad_idx;
                        w_commit = !w_bad_idx;
                    end
                end else if (w_expired) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (!activate_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_o  = (state_q == FINISH);
    assign error_o = (state_q == FINISH) && err_q;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            logic               w_we;
            logic [c_reg_w-1:0] reg_q;
            logic               upd_q;

            assign w_we = w_commit && (idx_q == 8'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= RESET_VAL;
                    upd_q <= 1'b0;
                end else begin
                    upd_q <= w_we;
                    if (w_we) begin
                        reg_q <= w_value;
                    end
                end
            end

            assign cfg_regs_o[gi*c_reg_w +: c_reg_w] = reg_q;
            assign cfg_update_o[gi]                  = upd_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_config_reg_bank_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_config_reg_bank_loader
// Brief  : Self-checking bench: three loader configurations against a register-array model.
// Rev    : 1.0
// ============================================================================
module tb_config_reg_bank_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  act;
    logic [2:0]  rdy;
    logic [7:0]  dat [3];
    logic [2:0]  done;
    logic [2:0]  err;
    logic [63:0] regs_a, regs_b;
    logic [95:0] regs_c;
    logic [3:0]  upd_a, upd_b;
    logic [2:0]  upd_c;

    int errors = 0;
    int checks = 0;

    // Instance 0: defaults, 1: short timeout, 2: 4-byte registers, no timeout.
    logic [31:0] exp_reg [3][4];
    int          nregs   [3] = '{4, 4, 3};
    int          nbytes  [3] = '{2, 2, 4};
    logic [31:0] rst_val [3] = '{32'h0, 32'h0, 32'hA5A5_0F0F};

    always #5 clk = ~clk;

    config_reg_bank_loader #(.NUM_REGS(4), .REG_BYTES(2), .RESET_VAL(16'h0000),
                             .TIMEOUT_CYCLES(1000000)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .activate_i(act[0]), .done_o(done[0]), .error_o(err[0]),
        .rx_data_i(dat[0]), .rx_ready_i(rdy[0]), .cfg_regs_o(regs_a), .cfg_update_o(upd_a));

    config_reg_bank_loader #(.NUM_REGS(4), .REG_BYTES(2), .RESET_VAL(16'h0000),
                             .TIMEOUT_CYCLES(50)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .activate_i(act[1]), .done_o(done[1]), .error_o(err[1]),
        .rx_data_i(dat[1]), .rx_ready_i(rdy[1]), .cfg_regs_o(regs_b), .cfg_update_o(upd_b));

    config_reg_bank_loader #(.NUM_REGS(3), .REG_BYTES(4), .RESET_VAL(32'hA5A5_0F0F),
                             .TIMEOUT_CYCLES(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .activate_i(act[2]), .done_o(done[2]), .error_o(err[2]),
        .rx_data_i(dat[2]), .rx_ready_i(rdy[2]), .cfg_regs_o(regs_c), .cfg_update_o(upd_c));

    function automatic logic [31:0] get_reg(input int d, input int i);
        case (d)
            0:       return {16'h0, regs_a[i*16 +: 16]};
            1:       return {16'h0, regs_b[i*16 +: 16]};
            default: return regs_c[i*32 +: 32];
        endcase
    endfunction

    function automatic logic [3:0] get_upd(input int d);
        case (d)
            0:       return upd_a;
            1:       return upd_b;
            default: return {1'b0, upd_c};
        endcase
    endfunction

    function automatic void model_write(input int d, input int idx, input logic [31:0] v);
        if (idx < nregs[d]) exp_reg[d][idx] = v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        dat[d] = b;
        rdy[d] = 1'b1;
        tick();
        rdy[d] = 1'b0;
    endtask

    task automatic start(input int d);
        act[d] = 1'b1;
        tick();
    endtask

    task automatic send_value(input int d, input logic [31:0] v, input int gap);
        for (int k = nbytes[d] - 1; k >= 0; k--) begin
            repeat (gap) tick();
            send_byte(d, v[k*8 +: 8]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        act   = '0;
        rdy   = '0;
        for (int d = 0; d < 3; d++) dat[d] = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < nregs[d]; i++) begin
                exp_reg[d][i] = rst_val[d];
                checks++;
                if (get_reg(d, i) !== rst_val[d]) begin
                    errors++;
                    $display("FAIL reset_reg dut%0d r%0d: got %h expected %h", d, i, get_reg(d, i), rst_val[d]);
                end
            end
            checks++;
            if (done[d] !== 1'b0 || err[d] !== 1'b0 || get_upd(d) !== 4'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: done=%b error=%b upd=%b expected 0/0/0", d, done[d], err[d], get_upd(d));
            end
        end
    endtask

    task automatic test_write();
        for (int rep = 0; rep < 2; rep++) begin
            start(0);
            send_byte(0, 8'h01);
            send_value(0, 32'h1234, rep);
            model_write(0, 1, 32'h1234);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (get_reg(0, i) !== exp_reg[0][i]) begin
                    errors++;
                    $display("FAIL write_reg r%0d: got %h expected %h", i, get_reg(0, i), exp_reg[0][i]);
                end
            end
            checks++;
            if (get_upd(0) !== 4'b0010 || done[0] !== 1'b1 || err[0] !== 1'b0) begin
                errors++;
                $display("FAIL write_flags: upd=%b done=%b error=%b expected 0010/1/0", get_upd(0), done[0], err[0]);
            end
            tick();
            checks++;
            if (get_upd(0) !== 4'b0000 || done[0] !== 1'b1) begin
                errors++;
                $display("FAIL write_hold: upd=%b done=%b expected 0000/1", get_upd(0), done[0]);
            end
            act[0] = 1'b0;
            tick();
            checks++;
            if (done[0] !== 1'b0) begin
                errors++;
                $display("FAIL write_done_drop: done=%b expected 0", done[0]);
            end
        end
    endtask

    task automatic test_bad_index();
        start(0);
        send_byte(0, 8'h07);
        send_value(0, 32'hAABB, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (get_reg(0, i) !== exp_reg[0][i]) begin
                errors++;
                $display("FAIL badidx_reg r%0d: got %h expected %h", i, get_reg(0, i), exp_reg[0][i]);
            end
        end
        checks++;
        if (get_upd(0) !== 4'b0000 || done[0] !== 1'b1 || err[0] !== 1'b1) begin
            errors++;
            $display("FAIL badidx_flags: upd=%b done=%b error=%b expected 0000/1/1", get_upd(0), done[0], err[0]);
        end
        act[0] = 1'b0;
        tick();
        checks++;
        if (done[0] !== 1'b0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL badidx_release: done=%b error=%b expected 0/0", done[0], err[0]);
        end
    endtask

    task automatic test_timeout();
        start(1);
        send_byte(1, 8'h00);
        send_byte(1, 8'h55);
        repeat (49) tick();
        checks++;
        if (done[1] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: done=%b expected 0 after 49 idle cycles", done[1]);
        end
        tick();
        checks++;
        if (done[1] !== 1'b1 || err[1] !== 1'b1 || get_upd(1) !== 4'h0) begin
            errors++;
            $display("FAIL timeout_fire: done=%b error=%b upd=%b expected 1/1/0000", done[1], err[1], get_upd(1));
        end
        checks++;
        if (get_reg(1, 0) !== exp_reg[1][0]) begin
            errors++;
            $display("FAIL timeout_reg0: got %h expected %h", get_reg(1, 0), exp_reg[1][0]);
        end
        act[1] = 1'b0;
        tick();

        // Byte arriving on the would-expire cycle keeps the transfer alive.
        start(1);
        send_byte(1, 8'h03);
        repeat (49) tick();
        send_byte(1, 8'hC3);
        checks++;
        if (done[1] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_byte_wins: done=%b expected 0", done[1]);
        end
        send_byte(1, 8'h3C);
        model_write(1, 3, 32'hC33C);
        checks++;
        if (get_reg(1, 3) !== exp_reg[1][3] || done[1] !== 1'b1 || err[1] !== 1'b0 || get_upd(1) !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_late_commit: reg3=%h done=%b error=%b upd=%b expected %h/1/0/1000",
                     get_reg(1, 3), done[1], err[1], get_upd(1), exp_reg[1][3]);
        end
        act[1] = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        start(0);
        send_byte(0, 8'h02);
        send_byte(0, 8'h99);
        act[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (done[0] !== 1'b0 || get_upd(0) !== 4'h0 || get_reg(0, 2) !== exp_reg[0][2]) begin
                errors++;
                $display("FAIL abort_cycle%0d: done=%b upd=%b reg2=%h expected 0/0000/%h",
                         c, done[0], get_upd(0), get_reg(0, 2), exp_reg[0][2]);
            end
        end
        start(0);
        send_byte(0, 8'h02);
        send_value(0, 32'hDEAD, 1);
        model_write(0, 2, 32'hDEAD);
        checks++;
        if (get_reg(0, 2) !== exp_reg[0][2] || get_upd(0) !== 4'b0100 || done[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_retry: reg2=%h upd=%b done=%b expected %h/0100/1",
                     get_reg(0, 2), get_upd(0), done[0], exp_reg[0][2]);
        end
        act[0] = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        v = $urandom;
        start(2);
        send_byte(2, 8'h01);
        send_value(2, v, 0);
        model_write(2, 1, v);
        checks++;
        if (get_reg(2, 1) !== exp_reg[2][1]) begin
            errors++;
            $display("FAIL wide_write_reg1: got %h expected %h", get_reg(2, 1), exp_reg[2][1]);
        end
        act[2] = 1'b0;
        tick();

        start(2);
        send_byte(2, 8'h00);
        send_byte(2, 8'h11);
        send_byte(2, 8'h22);
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < nregs[d]; i++) begin
                exp_reg[d][i] = rst_val[d];
                checks++;
                if (get_reg(d, i) !== rst_val[d]) begin
                    errors++;
                    $display("FAIL async_reset_reg dut%0d r%0d: got %h expected %h", d, i, get_reg(d, i), rst_val[d]);
                end
            end
        end
        checks++;
        if (done !== 3'b000 || get_upd(2) !== 4'h0) begin
            errors++;
            $display("FAIL async_reset_flags: done=%b upd=%b expected 000/0000", done, get_upd(2));
        end
        act[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        start(2);
        send_byte(2, 8'h00);
        send_value(2, 32'h0102_0304, 0);
        model_write(2, 0, 32'h0102_0304);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (get_reg(2, i) !== exp_reg[2][i]) begin
                errors++;
                $display("FAIL wide_after_reset r%0d: got %h expected %h", i, get_reg(2, i), exp_reg[2][i]);
            end
        end
        checks++;
        if (get_upd(2) !== 4'b0001 || done[2] !== 1'b1 || err[2] !== 1'b0) begin
            errors++;
            $display("FAIL wide_after_reset_flags: upd=%b done=%b error=%b expected 0001/1/0", get_upd(2), done[2], err[2]);
        end
        act[2] = 1'b0;
        tick();
    endtask

    task automatic test_random(input int d, input int iters);
        logic [7:0]  bytes [5];
        logic [31:0] v;
        logic [3:0]  exp_upd;
        int          idx, gap, abort_at, total;
        for (int it = 0; it < iters; it++) begin
            idx      = $urandom_range(0, nregs[d] + 1);
            v        = $urandom;
            if (nbytes[d] == 2) v = v & 32'h0000_FFFF;
            gap      = $urandom_range(0, 3);
            abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nbytes[d]) : -1;
            total    = 1 + nbytes[d];
            bytes[0] = 8'(idx);
            for (int k = 0; k < nbytes[d]; k++) bytes[1 + k] = v[(nbytes[d] - 1 - k)*8 +: 8];

            start(d);
            for (int j = 0; j < total; j++) begin
                if (j == abort_at) break;
                repeat (gap) tick();
                send_byte(d, bytes[j]);
            end

            if (abort_at >= 0) begin
                act[d] = 1'b0;
                tick();
                checks++;
                if (done[d] !== 1'b0 || get_upd(d) !== 4'h0) begin
                    errors++;
                    $display("FAIL rand_abort dut%0d it%0d: done=%b upd=%b expected 0/0000", d, it, done[d], get_upd(d));
                end
            end else begin
                model_write(d, idx, v);
                exp_upd = (idx < nregs[d]) ? 4'(1 << idx) : 4'h0;
                checks++;
                if (get_upd(d) !== exp_upd || done[d] !== 1'b1 || err[d] !== (idx >= nregs[d])) begin
                    errors++;
                    $display("FAIL rand_flags dut%0d it%0d idx%0d: upd=%b done=%b error=%b expected %b/1/%0d",
                             d, it, idx, get_upd(d), done[d], err[d], exp_upd, idx >= nregs[d]);
                end
                act[d] = 1'b0;
                tick();
                checks++;
                if (done[d] !== 1'b0 || get_upd(d) !== 4'h0) begin
                    errors++;
                    $display("FAIL rand_release dut%0d it%0d: done=%b upd=%b expected 0/0000", d, it, done[d], get_upd(d));
                end
            end
            for (int i = 0; i < nregs[d]; i++) begin
                checks++;
                if (get_reg(d, i) !== exp_reg[d][i]) begin
                    errors++;
                    $display("FAIL rand_reg dut%0d it%0d r%0d: got %h expected %h", d, it, i, get_reg(d, i), exp_reg[d][i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_index();
        test_timeout();
        test_abort();
        test_async_reset();
        test_random(0, 25);
        test_random(2, 10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
